// File: rtl/osc_reset_tick_gen.sv
// Oscillator-domain reset release: synchronizes POR and CCC lock, holds the fabric
// in reset until lock is stable and start-up has elapsed, then emits 1 us / 1 ms ticks.
module osc_reset_tick_gen #(
   parameter int CLK_FREQ_HZ    = 50000000,
   parameter int STARTUP_CYCLES = 1024,
   parameter int LOCK_FILTER    = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       LOCK,
   output logic       FAB_RESET_N,
   output logic       READY,
   output logic       TICK_US,
   output logic       TICK_MS,
   output logic [7:0] LOCK_LOSS_CNT,
   output logic [1:0] STATE
);

   localparam int US_DIV = CLK_FREQ_HZ / 1000000;
   localparam int US_W   = $clog2(US_DIV);
   localparam int SU_W   = $clog2(STARTUP_CYCLES + 1);
   localparam int LF_W   = $clog2(LOCK_FILTER + 1);

   localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
   localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CYCLES - 1);
   localparam logic [LF_W-1:0] LF_LAST = LF_W'(LOCK_FILTER - 1);
   localparam logic [9:0]      MS_LAST = 10'd999;

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STARTUP   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t          state;
   logic [1:0]      rst_sync;
   logic            rst_int_n;
   logic [1:0]      lock_sync;
   logic            lock_s;
   logic [LF_W-1:0] filt_cnt;
   logic [SU_W-1:0] su_cnt;
   logic [US_W-1:0] us_cnt;
   logic [9:0]      ms_cnt;
   logic [7:0]      loss_cnt;
   logic            run;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Reset asserts asynchronously and releases on the 2nd CLK edge after RESET_N rises.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rst_sync  <= 2'b00;
         lock_sync <= 2'b00;
      end else begin
         rst_sync  <= {rst_sync[0], 1'b1};
         lock_sync <= {lock_sync[0], LOCK};
      end
   end

   assign rst_int_n = rst_sync[1];
   assign lock_s    = lock_sync[1];

   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state    <= ST_RESET;
         filt_cnt <= '0;
         su_cnt   <= '0;
         loss_cnt <= 8'd0;
      end else begin
         case (state)
            ST_RESET: begin
               state    <= ST_WAIT_LOCK;
               filt_cnt <= '0;
            end
            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  filt_cnt <= '0;
               end else if (filt_cnt == LF_LAST) begin
                  state    <= ST_STARTUP;
                  filt_cnt <= '0;
                  su_cnt   <= '0;
               end else begin
                  filt_cnt <= filt_cnt + LF_W'(1);
               end
            end
            // Lock loss takes priority over the start-up terminal count.
            ST_STARTUP: begin
               if (!lock_s) begin
                  state    <= ST_WAIT_LOCK;
                  su_cnt   <= '0;
                  filt_cnt <= '0;
                  loss_cnt <= sat_inc(loss_cnt);
               end else if (su_cnt == SU_LAST) begin
                  state  <= ST_RUN;
                  su_cnt <= '0;
               end else begin
                  su_cnt <= su_cnt + SU_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state    <= ST_WAIT_LOCK;
                  filt_cnt <= '0;
                  loss_cnt <= sat_inc(loss_cnt);
               end
            end
            default: state <= ST_RESET;
         endcase
      end
   end

   // Timebase runs only while staying in RUN, so it restarts from zero on every entry.
   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         us_cnt <= '0;
         ms_cnt <= 10'd0;
      end else if (run && lock_s) begin
         us_cnt <= TICK_US ? '0 : us_cnt + US_W'(1);
         if (TICK_US) begin
            ms_cnt <= TICK_MS ? 10'd0 : ms_cnt + 10'd1;
         end
      end else begin
         us_cnt <= '0;
         ms_cnt <= 10'd0;
      end
   end

   assign run           = (state == ST_RUN);
   assign TICK_US       = run && (us_cnt == US_LAST);
   assign TICK_MS       = TICK_US && (ms_cnt == MS_LAST);
   assign FAB_RESET_N   = run;
   assign READY         = run;
   assign LOCK_LOSS_CNT = loss_cnt;
   assign STATE         = state;

endmodule
